// File: rtl/outgoing_response_buffer_if.sv
// AXI R-channel beat bundle shared by the reorder unit return path.
// receiver/slave take beats in; sender/master present beats out.
interface r_if #(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport receiver (input id, data, resp, last, valid, output ready);
    modport sender   (output id, data, resp, last, valid, input ready);
    modport slave    (input id, data, resp, last, valid, output ready);
    modport master   (output id, data, resp, last, valid, input ready);
endinterface

// File: rtl/outgoing_response_buffer.sv
// In-order R-beat FIFO with optional whole-burst release (store-and-forward).
// Valid never drops on a presented head beat; full forces cut-through drain.
module outgoing_response_buffer #(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int STORE_FWD  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    r_if.receiver                        r_in,
    r_if.sender                          r_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   bursts,
    output logic                         almost_full
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [RESP_WIDTH-1:0] mem_resp [DEPTH];
    logic                  mem_last [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_q, bur_q;
    logic          full, empty, push, pop, out_valid, head_last;
    logic          bur_inc, bur_dec;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_last = mem_last[rd_ptr];

    // The full term releases bursts longer than the buffer, avoiding deadlock.
    assign out_valid = (STORE_FWD != 0) ? (~empty & ((bur_q != '0) | full)) : ~empty;

    assign r_in.ready = ~full;
    assign push       = r_in.valid & ~full;
    assign pop        = out_valid & r_out.ready;
    assign bur_inc    = push & r_in.last;
    assign bur_dec    = pop & head_last;

    assign r_out.valid = out_valid;
    assign r_out.id    = out_valid ? mem_id[rd_ptr]   : '0;
    assign r_out.data  = out_valid ? mem_data[rd_ptr] : '0;
    assign r_out.resp  = out_valid ? mem_resp[rd_ptr] : '0;
    assign r_out.last  = out_valid ? head_last        : 1'b0;

    assign count       = cnt_q;
    assign bursts      = bur_q;
    assign almost_full = (cnt_q >= CW'(AF_LEVEL));

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_id[wr_ptr]   <= r_in.id;
            mem_data[wr_ptr] <= r_in.data;
            mem_resp[wr_ptr] <= r_in.resp;
            mem_last[wr_ptr] <= r_in.last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            bur_q  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (bur_inc && !bur_dec)      bur_q <= bur_q + CW'(1);
            else if (bur_dec && !bur_inc) bur_q <= bur_q - CW'(1);
        end
    end
endmodule

// File: tb/tb_outgoing_response_buffer.sv
// Bench for outgoing_response_buffer: one cut-through and one store-forward
// instance, scoreboard queues checked by a negedge monitor on every pop.
module tb_outgoing_response_buffer;
    typedef struct packed {
        logic [31:0] id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) ct_in ();
    r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) ct_out ();
    r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) sf_in ();
    r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) sf_out ();

    logic [3:0] ct_count, ct_bursts, sf_count, sf_bursts;
    logic       ct_af, sf_af;

    outgoing_response_buffer #(.DEPTH(8), .AF_LEVEL(6), .STORE_FWD(0)) dut_ct (
        .clk(clk), .rst(rst), .r_in(ct_in.receiver), .r_out(ct_out.sender),
        .count(ct_count), .bursts(ct_bursts), .almost_full(ct_af));

    outgoing_response_buffer #(.DEPTH(8), .AF_LEVEL(6), .STORE_FWD(1)) dut_sf (
        .clk(clk), .rst(rst), .r_in(sf_in.receiver), .r_out(sf_out.sender),
        .count(sf_count), .bursts(sf_bursts), .almost_full(sf_af));

    int    total = 0;
    int    bad   = 0;
    beat_t ct_q[$];
    beat_t sf_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted output beat must match the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (ct_out.valid && ct_out.ready) begin
            if (ct_q.size() == 0) check("ct_unexpected_beat", ct_out.data, 64'hDEAD);
            else begin
                e = ct_q.pop_front();
                check("ct_id", ct_out.id, e.id);
                check("ct_data", ct_out.data, e.data);
                check("ct_resp", ct_out.resp, e.resp);
                check("ct_last", ct_out.last, e.last);
            end
        end
        if (sf_out.valid && sf_out.ready) begin
            if (sf_q.size() == 0) check("sf_unexpected_beat", sf_out.data, 64'hDEAD);
            else begin
                e = sf_q.pop_front();
                check("sf_id", sf_out.id, e.id);
                check("sf_data", sf_out.data, e.data);
                check("sf_resp", sf_out.resp, e.resp);
                check("sf_last", sf_out.last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sf, input logic v, input beat_t b);
        if (sf) begin
            sf_in.valid = v; sf_in.id = b.id; sf_in.data = b.data;
            sf_in.resp = b.resp; sf_in.last = b.last;
        end else begin
            ct_in.valid = v; ct_in.id = b.id; ct_in.data = b.data;
            ct_in.resp = b.resp; ct_in.last = b.last;
        end
    endtask

    // Presents one beat, waits (bounded) for ready, completes on the next edge.
    task automatic push(input bit sf, input beat_t b);
        int n = 0;
        drive(sf, 1'b1, b);
        while (!(sf ? sf_in.ready : ct_in.ready) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("push_ready_timeout", 64'(n), 64'd0);
        if (sf) sf_q.push_back(b); else ct_q.push_back(b);
        tick();
        drive(sf, 1'b0, '0);
    endtask

    task automatic drain(input bit sf);
        int n = 0;
        if (sf) sf_out.ready = 1'b1; else ct_out.ready = 1'b1;
        while (((sf ? sf_count : ct_count) != 0) && n < 100) begin
            tick();
            n++;
        end
        check(sf ? "sf_drain_count" : "ct_drain_count", sf ? sf_count : ct_count, 0);
    endtask

    function automatic beat_t mk(input logic [31:0] id, input logic [63:0] d, input logic l);
        beat_t b;
        b.id = id; b.data = d; b.resp = d[1:0]; b.last = l;
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic lastq[$];
        logic l, hl;
        int   bexp;

        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        ct_out.ready = 1'b0;
        sf_out.ready = 1'b0;

        // Reset held two cycles
        tick(); tick();
        check("rst_valid", ct_out.valid, 0);
        check("rst_data", ct_out.data, 0);
        check("rst_id", ct_out.id, 0);
        check("rst_ready", ct_in.ready, 1);
        check("rst_count", ct_count, 0);
        check("rst_bursts", ct_bursts, 0);
        check("rst_af", ct_af, 0);
        check("rst_sf_valid", sf_out.valid, 0);
        rst = 1'b1;

        // Basic cut-through flow
        for (int i = 0; i < 3; i++) begin
            push(0, mk(32'd5, 64'hA0 + 64'(i), i == 2));
            check("basic_count", ct_count, 64'(i + 1));
            check("basic_valid", ct_out.valid, 1);
            check("basic_head", ct_out.data, 64'hA0);
        end
        check("basic_bursts", ct_bursts, 1);
        drain(0);
        check("basic_bursts_after", ct_bursts, 0);
        check("idle_data_zero", ct_out.data, 0);

        // Full and back-pressure
        ct_out.ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(0, mk(32'd6, 64'h100 + 64'(i), i == 7));
            check("af_level", ct_af, (i + 1) >= 6);
        end
        check("full_ready", ct_in.ready, 0);
        check("full_count", ct_count, 8);
        ct_out.ready = 1'b1;
        tick();
        ct_out.ready = 1'b0;
        check("one_pop_count", ct_count, 7);
        check("one_pop_ready", ct_in.ready, 1);
        drain(0);

        // Simultaneous push/pop at occupancy 3, pointers wrap
        ct_out.ready = 1'b0;
        push(0, mk(32'd7, 64'h200, 1'b0));
        push(0, mk(32'd7, 64'h201, 1'b1));
        push(0, mk(32'd7, 64'h202, 1'b0));
        lastq = '{1'b0, 1'b1, 1'b0};
        bexp = 1;
        check("sim_start_bursts", ct_bursts, 64'(bexp));
        for (int k = 0; k < 20; k++) begin
            l = 1'($urandom_range(0, 1));
            drive(0, 1'b1, mk(32'd7, 64'h203 + 64'(k), l));
            ct_q.push_back(mk(32'd7, 64'h203 + 64'(k), l));
            ct_out.ready = 1'b1;
            tick();
            hl = lastq.pop_front();
            lastq.push_back(l);
            bexp = bexp + int'(l) - int'(hl);
            check("sim_count", ct_count, 3);
            check("sim_bursts", ct_bursts, 64'(bexp));
        end
        drive(0, 1'b0, '0);
        drain(0);

        // Mid-operation reset with 5 beats stored
        ct_out.ready = 1'b0;
        for (int i = 0; i < 5; i++) push(0, mk(32'd8, 64'h400 + 64'(i), i == 4));
        check("pre_rst_count", ct_count, 5);
        rst = 1'b0;
        tick();
        check("mrst_count", ct_count, 0);
        check("mrst_valid", ct_out.valid, 0);
        check("mrst_ready", ct_in.ready, 1);
        check("mrst_bursts", ct_bursts, 0);
        ct_q.delete();
        rst = 1'b1;
        ct_out.ready = 1'b1;
        push(0, mk(32'd9, 64'hF00, 1'b1));
        drain(0);

        // Store-forward hold with gaps
        sf_out.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1, mk(32'd3, 64'h300 + 64'(i), i == 3));
            if (i < 3) begin
                check("sf_hold_valid", sf_out.valid, 0);
                tick();
                check("sf_gap_valid", sf_out.valid, 0);
                tick();
                check("sf_gap_valid", sf_out.valid, 0);
            end
        end
        check("sf_release_valid", sf_out.valid, 1);
        check("sf_release_bursts", sf_bursts, 1);
        for (int j = 0; j < 4; j++) begin
            check("sf_pop_valid", sf_out.valid, 1);
            check("sf_pop_count", sf_count, 64'(4 - j));
            tick();
        end
        check("sf_done_count", sf_count, 0);
        check("sf_done_bursts", sf_bursts, 0);
        check("sf_done_valid", sf_out.valid, 0);

        // Oversized burst escape
        for (int i = 0; i < 8; i++) begin
            push(1, mk(32'd4, 64'h500 + 64'(i), 1'b0));
            if (i == 6) check("big_valid_before_full", sf_out.valid, 0);
        end
        check("big_full_count", sf_count, 8);
        check("big_full_bursts", sf_bursts, 0);
        check("big_full_valid", sf_out.valid, 1);
        check("big_full_ready", sf_in.ready, 0);
        drive(1, 1'b1, mk(32'd4, 64'h508, 1'b0));
        tick();
        check("big_no_push_on_pop", sf_count, 7);
        check("big_ready_back", sf_in.ready, 1);
        for (int i = 8; i < 12; i++) push(1, mk(32'd4, 64'h500 + 64'(i), i == 11));
        drain(1);
        check("big_bursts_end", sf_bursts, 0);

        tick(); tick();
        check("ct_sb_empty", 64'(ct_q.size()), 0);
        check("sf_sb_empty", 64'(sf_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/outgoing_response_buffer.md
# outgoing_response_buffer

Parameterised FIFO for AXI R (read-data) beats on the return path of the read reorder unit. It accepts beats from the response ordering logic on `r_in`, stores them in arrival order, and presents them to the AXI master on `r_out`. An optional store-and-forward mode holds back a burst until its last beat has been buffered. It is the response-side counterpart of the AR request buffer.

## Interface
Parameters:
- `ID_WIDTH`, 32: RID width.
- `DATA_WIDTH`, 64: RDATA width.
- `RESP_WIDTH`, 2: RRESP width.
- `DEPTH`, 8: beat entries stored, ≥2.
- `AF_LEVEL`, 6: `almost_full` asserts when occupancy ≥ `AF_LEVEL`, 1..DEPTH.
- `STORE_FWD`, 1: 1 selects whole-burst release; 0 selects cut-through.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: reset, synchronous, active-low. Sampled on the `clk` rising edge.
- `r_in`, `r_if.receiver`, bundle: beats from the ordering logic. Fields `id`, `data`, `resp`, `last`, `valid`, `ready`.
- `r_out`, `r_if.sender`, bundle: beats toward the AXI master. Same fields.
- `count`, output, `$clog2(DEPTH+1)`: current occupancy in beats.
- `bursts`, output, `$clog2(DEPTH+1)`: stored entries with `last`=1.
- `almost_full`, output, 1: occupancy ≥ `AF_LEVEL`.

## Operation
- Storage: circular array of {id, data, resp, last} entries.
  - `wr_ptr` and `rd_ptr` wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
  - Beat counter `count` and burst counter `bursts`.
- Push:
  - `r_in.ready` = ~full.
  - A push occurs when `r_in.valid & r_in.ready`. It writes the entry at `wr_ptr` and advances `wr_ptr`.
- Pop:
  - A pop occurs when `r_out.valid & r_out.ready`. It advances `rd_ptr`.
  - The head entry drives `r_out` fields combinationally.
  - While `r_out.valid`=0, all `r_out` payload fields are driven to 0.
- `r_out.valid`:
  - When `STORE_FWD`=0: ~empty.
  - When `STORE_FWD`=1: ~empty & (`bursts` ≠ 0 | full).
  - The `full` term is the deadlock escape for bursts longer than DEPTH. While full with no buffered last beat, beats drain in cut-through fashion.
- Count update:
  - push only: `count`+1.
  - pop only: `count`-1.
  - push and pop together: unchanged.
- Burst counter update:
  - +1 on a push with `r_in.last`=1.
  - -1 on a pop with head `last`=1.
  - Both events in the same cycle: unchanged.
- Release is strictly in order. No reordering and no ID inspection in this block.
- Once `r_out.valid` is asserted for a head beat, it stays asserted until that beat is popped.
  - Store-forward cannot withdraw valid, because `bursts` only decreases on a pop of that same beat and `full` only clears by a pop.
  - The payload at the head stays stable while valid is asserted.
- Reset (`rst`=0 at a clock edge):
  - Pointers, `count` and `bursts` cleared.
  - Array contents are not cleared.
  - Takes effect regardless of in-flight handshakes; any beat presented in that cycle is dropped.

## Timing
- Reset values:
  - `r_out.valid`=0 and all `r_out` payload fields 0.
  - `r_in.ready`=1.
  - `count`=0, `bursts`=0, `almost_full`=0.
- Cut-through latency: a beat pushed at edge N appears on `r_out` (valid=1) in the cycle after edge N. No same-cycle bypass.
- Store-forward latency: the first beat of a burst becomes valid the cycle after its `last` beat is pushed.
- When full, `r_in.ready`=0.
  - A simultaneous pop in that cycle does not enable a push. Ready depends only on registered state.
  - Throughput when full is one beat every other cycle at worst.
- When empty, a push and no pop occur, and `count` becomes 1 the next cycle.
- `count`, `bursts` and `almost_full` are derived from registered state only. They are combinational from flops and glitch-free relative to `clk`.

## Test plan
- Reset and basic flow, `STORE_FWD`=0:
  - Hold `rst`=0 for 2 cycles, then push 3 beats (id 5, data 0xA0/A1/A2, last on the third).
  - Required: `r_out` shows the same beats in order, each valid starting 1 cycle after its push; `count` sequence 1,2,3; `bursts`=1 after the third push.
- Full and back-pressure:
  - Hold `r_out.ready`=0 and push 8 beats.
  - Required: `r_in.ready`=0 and `count`=8 after the 8th; `almost_full`=1 from occupancy 6.
  - Release `r_out.ready` and check that a single pop re-raises `r_in.ready` the next cycle.
- Store-forward hold, `STORE_FWD`=1:
  - Push a 4-beat burst with 2-cycle gaps between beats.
  - Required: `r_out.valid`=0 until the cycle after beat 4 is pushed, then 4 consecutive pops with `last` only on beat 4, then `bursts`=0.
- Oversized burst escape, `STORE_FWD`=1:
  - Push a 12-beat burst with `r_out.ready`=1.
  - Required: valid asserts once `count`=8 with `bursts`=0, beats drain without deadlock, and all 12 beats are delivered in order.
- Simultaneous push and pop:
  - Hold both handshakes active for 20 cycles at `count`=3 with random `last`.
  - Required: `count` stays 3; `bursts` tracks the expected value; pointers wrap past index 7 with the data intact.
- Mid-operation reset:
  - Assert `rst`=0 for one cycle with 5 beats stored.
  - Required: the next cycle shows `count`=0, `r_out.valid`=0, `r_in.ready`=1; a subsequent push delivers fresh data only.
